// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Launches one frame at a time, waits for done (with watchdog), then guard gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Gnt,
  output logic [2:0]           o_Gnt_Id,
  output logic                 o_Tx_Dv,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(TIMEOUT_CYCLES);

  localparam logic [TW-1:0]  WD_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [IDW-1:0] RR_RESET = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_GAP       = 2'd2
  } state_t;

  // With no guard gap a finished frame goes straight back to arbitration.
  localparam state_t S_AFTER = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t               r_state;
  state_t               w_state_next;
  logic [IDW-1:0]       r_rr;
  logic [IDW-1:0]       w_rr_next;
  logic [TW-1:0]        r_wd_cnt;
  logic [TW-1:0]        w_wd_next;
  logic [7:0]           r_gap_cnt;
  logic [7:0]           w_gap_next;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   w_gnt_next;
  logic [2:0]           r_gnt_id;
  logic [2:0]           w_gnt_id_next;
  logic                 r_tx_dv;
  logic                 w_tx_dv_next;
  logic [7:0]           r_tx_byte;
  logic [7:0]           w_tx_byte_next;
  logic                 r_busy;
  logic                 r_timeout;
  logic                 w_timeout_next;

  logic                 w_any;
  logic [IDW-1:0]       w_pick;
  logic [IDW-1:0]       w_idx;
  logic [7:0]           w_req_byte [NUM_REQ];
  logic [NUM_REQ-1:0]   w_pick_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_req_byte[gi]    = i_Req_Byte[8*gi +: 8];
      assign w_pick_onehot[gi] = (w_pick == IDW'(gi));
    end
  endgenerate

  // Search upward from rr+1 with wrap; the last granted requester goes last.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = IDW'((int'(r_rr) + off) % NUM_REQ);
      if (!w_any && i_Req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_rr_next      = r_rr;
    w_wd_next      = r_wd_cnt;
    w_gap_next     = r_gap_cnt;
    w_gnt_next     = '0;
    w_gnt_id_next  = r_gnt_id;
    w_tx_dv_next   = 1'b0;
    w_tx_byte_next = r_tx_byte;
    w_timeout_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_gnt_next     = w_pick_onehot;
          w_gnt_id_next  = 3'(w_pick);
          w_tx_dv_next   = 1'b1;
          w_tx_byte_next = w_req_byte[w_pick];
          w_rr_next      = w_pick;
          w_wd_next      = '0;
          w_state_next   = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // Done is checked first so it wins over the terminal count.
        if (i_Tx_Done) begin
          w_wd_next    = '0;
          w_gap_next   = '0;
          w_state_next = S_AFTER;
        end else if (r_wd_cnt == WD_LAST) begin
          w_timeout_next = 1'b1;
          w_wd_next      = '0;
          w_gap_next     = '0;
          w_state_next   = S_AFTER;
        end else begin
          w_wd_next = r_wd_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_gap_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_gap_next = r_gap_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr      <= RR_RESET;
      r_wd_cnt  <= '0;
      r_gap_cnt <= '0;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_rr      <= w_rr_next;
      r_wd_cnt  <= w_wd_next;
      r_gap_cnt <= w_gap_next;
      r_gnt     <= w_gnt_next;
      r_gnt_id  <= w_gnt_id_next;
      r_tx_dv   <= w_tx_dv_next;
      r_tx_byte <= w_tx_byte_next;
      r_busy    <= (w_state_next != S_IDLE);
      r_timeout <= w_timeout_next;
    end
  end

  assign o_Gnt     = r_gnt;
  assign o_Gnt_Id  = r_gnt_id;
  assign o_Tx_Dv   = r_tx_dv;
  assign o_Tx_Byte = r_tx_byte;
  assign o_Busy    = r_busy;
  assign o_Timeout = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance 0 has no gap and a long watchdog,
// instance 1 has a 5-cycle gap and a 16-cycle watchdog; the transmitter is stubbed.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0]   req      [2];
  logic [8*N-1:0] req_byte [2];
  logic           tx_done  [2];
  logic [N-1:0]   gnt      [2];
  logic [2:0]     gid      [2];
  logic           dv       [2];
  logic [7:0]     tbyte    [2];
  logic           busy     [2];
  logic           tmo      [2];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(1024)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_Req(req[0]), .i_Req_Byte(req_byte[0]),
    .o_Gnt(gnt[0]), .o_Gnt_Id(gid[0]), .o_Tx_Dv(dv[0]), .o_Tx_Byte(tbyte[0]),
    .i_Tx_Done(tx_done[0]), .o_Busy(busy[0]), .o_Timeout(tmo[0])
  );

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(5), .TIMEOUT_CYCLES(16)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_Req(req[1]), .i_Req_Byte(req_byte[1]),
    .o_Gnt(gnt[1]), .o_Gnt_Id(gid[1]), .o_Tx_Dv(dv[1]), .o_Tx_Byte(tbyte[1]),
    .i_Tx_Done(tx_done[1]), .o_Busy(busy[1]), .o_Timeout(tmo[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; req_byte[d] = '0; tx_done[d] = 1'b0;
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Called at a negedge; returns the edge index whose update raised o_Tx_Dv.
  task automatic wait_dv(input int d, input int lim, input string tag, output int at);
    int n = 0;
    while (dv[d] !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    check_val({tag, "_dv"}, 32'(dv[d]), 32'd1);
    at = cyc;
  endtask

  // Stub transmitter: frame lasts len clocks, then one done pulse.
  task automatic finish_frame(input int d, input int len, output int done_edge);
    int ovl = 0;
    repeat (len) begin
      tick();
      if (dv[d] === 1'b1) ovl++;
    end
    tx_done[d] = 1'b1;
    tick();
    tx_done[d] = 1'b0;
    if (dv[d] === 1'b1) ovl++;
    done_edge = cyc;
    check_val("no_overlap", ovl, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int at, at2, de, n, cnt;
    logic [1:0] exp_id;

    // Reset state
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; req_byte[d] = '0; tx_done[d] = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check_val("rst_dv", 32'(dv[d]), 0);
      check_val("rst_gnt", 32'(gnt[d]), 0);
      check_val("rst_byte", 32'(tbyte[d]), 0);
      check_val("rst_gid", 32'(gid[d]), 0);
      check_val("rst_busy", 32'(busy[d]), 0);
      check_val("rst_tmo", 32'(tmo[d]), 0);
    end
    rst_n = 1'b1;
    tick();

    // 1: single request, launch one clock later
    req[0] = 4'b0001; req_byte[0] = 32'h0000008B;
    tick();
    check_val("t1_dv", 32'(dv[0]), 1);
    check_val("t1_gnt", 32'(gnt[0]), 32'h1);
    check_val("t1_byte", 32'(tbyte[0]), 32'h8B);
    check_val("t1_gid", 32'(gid[0]), 0);
    check_val("t1_busy", 32'(busy[0]), 1);
    req[0] = '0;
    tick();
    check_val("t1_dv_pulse", 32'(dv[0]), 0);
    check_val("t1_gnt_pulse", 32'(gnt[0]), 0);
    check_val("t1_busy_frame", 32'(busy[0]), 1);
    finish_frame(0, 20, de);
    check_val("t1_busy_fall", 32'(busy[0]), 0);
    check_val("t1_byte_hold", 32'(tbyte[0]), 32'h8B);
    repeat (3) tick();
    check_val("t1_idle_dv", 32'(dv[0]), 0);
    check_val("t1_idle_gid", 32'(gid[0]), 0);

    // 2: all requesting, rotation 0,1,2,3,0
    do_reset();
    req[0] = 4'b1111; req_byte[0] = 32'hA3A2A1A0;
    de = 0;
    for (int i = 0; i < 5; i++) begin
      exp_id = 2'(i % 4);
      wait_dv(0, 5, "t2", at);
      check_val("t2_gid", 32'(gid[0]), 32'(exp_id));
      check_val("t2_gnt", 32'(gnt[0]), 32'(1) << exp_id);
      check_val("t2_byte", 32'(tbyte[0]), 32'hA0 + 32'(exp_id));
      if (i > 0) check_val("t2_relaunch", at - de, 1);
      finish_frame(0, 20, de);
    end
    req[0] = '0;
    tick();

    // 3: wrap-around after requester 3
    do_reset();
    req[0] = 4'b1000; req_byte[0] = 32'h33000030;
    wait_dv(0, 5, "t3a", at);
    check_val("t3_first_gid", 32'(gid[0]), 3);
    req[0] = 4'b1001;
    finish_frame(0, 10, de);
    wait_dv(0, 5, "t3b", at);
    check_val("t3_wrap_gid", 32'(gid[0]), 0);
    check_val("t3_wrap_byte", 32'(tbyte[0]), 32'h30);
    req[0] = 4'b1000;
    finish_frame(0, 10, de);
    wait_dv(0, 5, "t3c", at);
    check_val("t3_then_gid", 32'(gid[0]), 3);
    req[0] = '0;
    finish_frame(0, 10, de);

    // 4: guard gap of 5, second launch GAP+1 edges after done edge
    do_reset();
    req[1] = 4'b0011; req_byte[1] = 32'h00005150;
    wait_dv(1, 5, "t4a", at);
    check_val("t4_first_gid", 32'(gid[1]), 0);
    req[1] = 4'b0010;
    finish_frame(1, 4, de);
    tx_done[1] = 1'b1;
    tick();
    tx_done[1] = 1'b0;
    check_val("t4_busy_gap", 32'(busy[1]), 1);
    wait_dv(1, 20, "t4b", at);
    check_val("t4_gap_latency", at - de, 6);
    check_val("t4_second_gid", 32'(gid[1]), 1);
    check_val("t4_second_byte", 32'(tbyte[1]), 32'h51);
    req[1] = '0;
    finish_frame(1, 4, de);

    // 5: watchdog abort 16 clocks after launch, then next request served
    req[1] = 4'b0100; req_byte[1] = 32'h00620000;
    wait_dv(1, 20, "t5a", at);
    req[1] = 4'b1000; req_byte[1] = 32'h73000000;
    n = 0;
    while (tmo[1] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_val("t5_tmo_latency", cyc - at, 16);
    check_val("t5_byte_held", 32'(tbyte[1]), 32'h62);
    tick();
    check_val("t5_tmo_pulse", 32'(tmo[1]), 0);
    wait_dv(1, 20, "t5b", at2);
    check_val("t5_next_gid", 32'(gid[1]), 3);
    check_val("t5_next_byte", 32'(tbyte[1]), 32'h73);
    req[1] = '0;
    // done sampled on the same edge as the terminal count
    repeat (15) tick();
    tx_done[1] = 1'b1;
    tick();
    tx_done[1] = 1'b0;
    check_val("t5_done_wins_tmo", 32'(tmo[1]), 0);
    check_val("t5_done_wins_busy", 32'(busy[1]), 1);
    cnt = 0;
    repeat (12) begin
      tick();
      if (tmo[1] === 1'b1) cnt++;
    end
    check_val("t5_no_late_tmo", cnt, 0);
    check_val("t5_back_idle", 32'(busy[1]), 0);

    // 6: reset 300 clocks into a frame
    do_reset();
    req[0] = 4'b0100; req_byte[0] = 32'h005A0000;
    wait_dv(0, 5, "t6a", at);
    req[0] = '0;
    repeat (300) tick();
    check_val("t6_busy_pre", 32'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    check_val("t6_async_busy", 32'(busy[0]), 0);
    check_val("t6_async_byte", 32'(tbyte[0]), 0);
    check_val("t6_async_gid", 32'(gid[0]), 0);
    check_val("t6_async_dv", 32'(dv[0]), 0);
    check_val("t6_async_gnt", 32'(gnt[0]), 0);
    check_val("t6_async_tmo", 32'(tmo[0]), 0);
    tick();
    rst_n = 1'b1;
    req[0] = 4'b1111; req_byte[0] = 32'hA3A2A1A0;
    wait_dv(0, 5, "t6b", at);
    check_val("t6_post_gid", 32'(gid[0]), 0);
    check_val("t6_post_gnt", 32'(gnt[0]), 32'h1);
    check_val("t6_post_byte", 32'(tbyte[0]), 32'hA0);
    req[0] = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
